cpu_controller: RTL
===================

CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 Parameters: none; opcode width fixed at 3 bits, phase width fixed at 3 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 opcode  input  3  instruction-register opcode field; must be stable from phase 3 through phase 7.
REQ-005 zero  input  1  accumulator-is-zero flag, sampled combinationally.
REQ-006 sel  output  1  address mux select: 1 = PC, 0 = IR operand.
REQ-007 rd  output  1  memory read strobe.
REQ-008 ld_ir  output  1  instruction register load enable.
REQ-009 ld_ac  output  1  accumulator load enable.
REQ-010 inc_pc  output  1  program counter increment.
REQ-011 ld_pc  output  1  program counter load (jump).
REQ-012 wr  output  1  memory write strobe.
REQ-013 data_e  output  1  accumulator-to-data-bus drive enable.
REQ-014 halt  output  1  CPU halted indication.
REQ-015 phase  output  3  current phase; debug/observation only.

Function
REQ-016 Phase sequence: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE.
REQ-017 When not halted, phase advances by one every cycle and wraps 7 -> 0.
REQ-018 Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
REQ-019 ALUOP = opcode in {ADD, AND, XOR, LDA}.
REQ-020 Outputs decode combinationally from phase, opcode, zero and the halted flag; any strobe not listed for a phase is 0.
REQ-021 Phase 0: sel=1.
REQ-022 Phase 1: sel=1, rd=1.
REQ-023 Phases 2 and 3: sel=1, rd=1, ld_ir=1.
REQ-024 Phase 4: inc_pc=1; halt=1 if opcode==HLT.
REQ-025 Phase 5: rd=ALUOP.
REQ-026 Phase 6: rd=ALUOP, inc_pc=(opcode==SKZ && zero), ld_pc=(opcode==JMP), data_e=(opcode==STO).
REQ-027 Phase 7: rd=ALUOP, ld_ac=ALUOP, ld_pc=(opcode==JMP), wr=(opcode==STO), data_e=(opcode==STO).
REQ-028 Halt entry: the rising edge that ends phase 4 with opcode==HLT sets the halted flag; phase then stays at 5.
REQ-029 While halted: halt=1, all other strobes 0, phase frozen; only rst exits the halted state.
REQ-030 wr is never asserted in the same cycle as rd; ld_pc and inc_pc are never both 1.
REQ-031 Opcode changes outside phases 3-7 have no effect on state.

Reset
REQ-032 rst=1 at a rising edge forces phase=0 and halted=0, overriding advance and halt entry in the same cycle.
REQ-033 Output values while phase=0 and not halted: sel=1, all other strobes 0, phase=0.
REQ-034 Reset mid-instruction, including while halted, restarts at INST_ADDR on the next cycle without emitting partial strobes.

Structure
REQ-035 Opcode constants and phase encodings live in the shared header cpu_defs.vh, which is used by the controller, the ALU and the testbench.
REQ-036 The phase sequencing is a sub-module, phase_counter: 3-bit, synchronous reset, enable input; the controller drives enable = !halted.
REQ-037 The halted flag is the controller's only other state element.

Verification
REQ-038 Reset then run LDA (opcode=5) for 8 cycles -> rd=1 in phases 1,2,3,5,6,7; ld_ir=1 in phases 2,3; ld_ac=1 only in phase 7; inc_pc=1 only in phase 4.
REQ-039 STO (opcode=6) -> data_e=1 in phases 6,7; wr=1 only in phase 7; rd=0 in phases 5-7.
REQ-040 SKZ with zero=1 -> inc_pc=1 in phases 4 and 6; SKZ with zero=0 -> inc_pc=1 in phase 4 only.
REQ-041 JMP (opcode=7) -> ld_pc=1 in phases 6,7; inc_pc=0 in those phases.
REQ-042 HLT (opcode=0) -> halt=1 in phase 4, then halt=1 and phase=5 held for 20 cycles with all strobes 0; assert rst -> phase=0, halt=0 on the next cycle.
REQ-043 Assert rst at phase 6 of an STO -> wr never pulses; next cycle phase=0 and sel=1.

Source files
------------

// File: rtl/cpu_controller_pkg.sv
// cpu_controller_pkg: shared definitions for the CPU controller, its phase
// sequencer and anything that needs to speak opcodes or phases.
//   opcode_e : 3-bit instruction opcode encodings
//   phase_e  : 3-bit instruction phase encodings (sequencer order)
//   is_aluop : opcodes that read an operand and load the accumulator
package cpu_controller_pkg;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_e;

    function automatic logic is_aluop(input opcode_e op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/cpu_controller_phase_counter.sv
// phase_counter: 3-bit instruction phase sequencer.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset to INST_ADDR
//   en    : advance one phase per cycle when high, hold when low
//   phase : current phase, wraps STORE -> INST_ADDR
module phase_counter
    import cpu_controller_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    output phase_e phase
);

    phase_e phase_q;
    phase_e phase_d;

    always_comb begin
        phase_d = phase_q;
        if (en) begin
            // natural 3-bit overflow gives the 7 -> 0 wrap
            phase_d = phase_e'(phase_q + 3'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= INST_ADDR;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: eight-phase control sequencer for a simple accumulator CPU.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset (also leaves the halted state)
//   opcode : IR opcode field, stable from IDLE through STORE
//   zero   : accumulator-is-zero flag
//   sel    : address mux select (1 = PC, 0 = IR operand)
//   rd     : memory read strobe        wr     : memory write strobe
//   ld_ir  : IR load enable            ld_ac  : accumulator load enable
//   inc_pc : PC increment              ld_pc  : PC load (jump)
//   data_e : accumulator drives data bus
//   halt   : CPU halted indication     phase  : current phase (debug)
// Strobes are decoded combinationally from phase, opcode, zero and halted.
module cpu_controller
    import cpu_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       ld_ac,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       wr,
    output logic       data_e,
    output logic       halt,
    output logic [2:0] phase
);

    opcode_e op;
    phase_e  phase_w;
    logic    halted_q;
    logic    halted_d;
    logic    aluop;

    assign op    = opcode_e'(opcode);
    assign aluop = is_aluop(op);

    phase_counter u_phase_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (!halted_q),
        .phase (phase_w)
    );

    // The edge that leaves OP_ADDR with HLT still advances the sequencer
    // (enable is taken from the pre-edge flag), so the freeze lands on OP_FETCH.
    always_comb begin
        halted_d = halted_q;
        if (!halted_q && (phase_w == OP_ADDR) && (op == HLT)) begin
            halted_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        ld_ac  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        if (halted_q) begin
            halt = 1'b1;
        end else begin
            unique case (phase_w)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (op == HLT);
                end
                OP_FETCH: begin
                    rd = aluop;
                end
                ALU_OP: begin
                    rd     = aluop;
                    inc_pc = (op == SKZ) && zero;
                    ld_pc  = (op == JMP);
                    data_e = (op == STO);
                end
                STORE: begin
                    rd     = aluop;
                    ld_ac  = aluop;
                    ld_pc  = (op == JMP);
                    wr     = (op == STO);
                    data_e = (op == STO);
                end
                default: begin
                end
            endcase
        end
    end

    assign phase = phase_w;

endmodule
